// File: rtl/regfile_banked.sv
// Banked register file: switchable banks for the low register range, a shared upper range,
// two combinational read ports (single and pair), prioritised write ports and an atomic increment.
module regfile_banked #(
   parameter int DATA_W      = 4,
   parameter int NUM_REGS    = 16,
   parameter int NUM_BANKS   = 2,
   parameter int BANKED_REGS = 8,
   parameter int BYPASS      = 1,
   localparam int AW         = $clog2(NUM_REGS),
   localparam int PW         = AW - 1,
   localparam int BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bank_req,
   input  logic [BW-1:0]         bank_id,
   output logic [BW-1:0]         cur_bank,
   input  logic [AW-1:0]         rda_addr,
   output logic [DATA_W-1:0]     rda_data,
   input  logic [PW-1:0]         rdp_addr,
   output logic [2*DATA_W-1:0]   rdp_data,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  pw_en,
   input  logic [PW-1:0]         pw_addr,
   input  logic [2*DATA_W-1:0]   pw_data,
   input  logic                  inc_en,
   input  logic [AW-1:0]         inc_addr,
   output logic                  inc_zero,
   output logic                  inc_valid
);

   localparam int COMMON_REGS = NUM_REGS - BANKED_REGS;
   localparam int CELLS       = NUM_BANKS * BANKED_REGS + COMMON_REGS;
   localparam int CW          = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};

   // Banked cells occupy [0, NUM_BANKS*BANKED_REGS); common cells follow them.
   function automatic logic [CW-1:0] cell_of(input logic [AW-1:0] addr, input logic [BW-1:0] bank);
      int idx;
      if (int'(addr) < BANKED_REGS) begin
         idx = int'(bank) * BANKED_REGS + int'(addr);
      end else begin
         idx = NUM_BANKS * BANKED_REGS + int'(addr) - BANKED_REGS;
      end
      return CW'(idx);
   endfunction

   logic [DATA_W-1:0] mem_r  [CELLS];
   logic [DATA_W-1:0] next_s [CELLS];
   logic [CW-1:0]     pe_cell_s;
   logic [CW-1:0]     po_cell_s;
   logic [CW-1:0]     wr_cell_s;
   logic [CW-1:0]     inc_cell_s;
   logic [CW-1:0]     rda_cell_s;
   logic [CW-1:0]     rpe_cell_s;
   logic [CW-1:0]     rpo_cell_s;
   logic              bank_ok_s;

   assign pe_cell_s  = cell_of({pw_addr, 1'b0}, cur_bank);
   assign po_cell_s  = cell_of({pw_addr, 1'b1}, cur_bank);
   assign wr_cell_s  = cell_of(wr_addr, cur_bank);
   assign inc_cell_s = cell_of(inc_addr, cur_bank);
   assign rda_cell_s = cell_of(rda_addr, cur_bank);
   assign rpe_cell_s = cell_of({rdp_addr, 1'b0}, cur_bank);
   assign rpo_cell_s = cell_of({rdp_addr, 1'b1}, cur_bank);

   assign bank_ok_s = bank_req && (NUM_BANKS > 1) && (int'(bank_id) < NUM_BANKS);

   // Per-cell commit value after priority resolution: pair write, then single write, then increment.
   always_comb begin
      for (int c = 0; c < CELLS; c++) begin
         if (pw_en && (pe_cell_s == CW'(c))) begin
            next_s[c] = pw_data[2*DATA_W-1:DATA_W];
         end else if (pw_en && (po_cell_s == CW'(c))) begin
            next_s[c] = pw_data[DATA_W-1:0];
         end else if (wr_en && (wr_cell_s == CW'(c))) begin
            next_s[c] = wr_data;
         end else if (inc_en && (inc_cell_s == CW'(c))) begin
            next_s[c] = mem_r[c] + ONE;
         end else begin
            next_s[c] = mem_r[c];
         end
      end
   end

   assign rda_data = (BYPASS != 0) ? next_s[rda_cell_s] : mem_r[rda_cell_s];
   assign rdp_data = (BYPASS != 0) ? {next_s[rpe_cell_s], next_s[rpo_cell_s]}
                                   : {mem_r[rpe_cell_s], mem_r[rpo_cell_s]};

   // Storage, bank selection and increment flags; inc_zero reports what the cell really received.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CELLS; c++) begin
            mem_r[c] <= ZERO;
         end
         cur_bank  <= {BW{1'b0}};
         inc_valid <= 1'b0;
         inc_zero  <= 1'b0;
      end else begin
         for (int c = 0; c < CELLS; c++) begin
            mem_r[c] <= next_s[c];
         end
         if (bank_ok_s) begin
            cur_bank <= bank_id;
         end else begin
            cur_bank <= cur_bank;
         end
         inc_valid <= inc_en;
         if (inc_en) begin
            inc_zero <= (next_s[inc_cell_s] == ZERO);
         end else begin
            inc_zero <= inc_zero;
         end
      end
   end

endmodule

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
- Parametrised, banked successor to the 16x4 index register file of the Miyamii-4000 datapath, sitting between the decode/execute unit and the ALU.
- Adds the following on top of single and pair register access:
  - Switchable register banks for the low register range, with a common upper range.
  - Two independent read ports, with optional same-cycle write bypass.
  - Atomic increment port that reports a wrap-to-zero flag, for increment-and-skip instructions.

Parameters:
- DATA_W, 4: width of one register in bits.
- NUM_REGS, 16: architectural registers visible per bank. Must be even and a power of 2.
- NUM_BANKS, 2: number of banks for the banked range. Must be a power of 2, ≥1.
- BANKED_REGS, 8: addresses 0..BANKED_REGS-1 are banked; the rest are common to all banks. Must be even and ≤NUM_REGS.
- BYPASS, 1: 1 = read ports return same-cycle write data; 0 = read ports return stored array contents.
- Derived: AW = clog2(NUM_REGS), PW = AW-1, BW = max(1, clog2(NUM_BANKS)).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- bank_req  in  1  request bank switch.
- bank_id  in  BW  target bank for bank_req.
- cur_bank  out  BW  currently active bank (registered).
- rda_addr  in  AW  read port A address.
- rda_data  out  DATA_W  read port A data.
- rdp_addr  in  PW  pair read address.
- rdp_data  out  2*DATA_W  pair read data: {even register, odd register}.
- wr_en  in  1  single-register write enable.
- wr_addr  in  AW  single-register write address.
- wr_data  in  DATA_W  single-register write data.
- pw_en  in  1  pair write enable.
- pw_addr  in  PW  pair write address.
- pw_data  in  2*DATA_W  pair write data: high half to even register, low half to odd register.
- inc_en  in  1  increment request.
- inc_addr  in  AW  register to increment.
- inc_zero  out  1  registered; 1 = last increment wrapped the register to 0.
- inc_valid  out  1  registered; pulses 1 cycle after inc_en.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All NUM_BANKS*BANKED_REGS + (NUM_REGS-BANKED_REGS) storage cells = 0.
  - cur_bank = 0, inc_zero = 0, inc_valid = 0.
  - Reset mid-operation aborts any in-flight bank switch or increment. No write or increment is committed on the edge at which reset is released.
- Address mapping:
  - Address a < BANKED_REGS selects cell (cur_bank, a).
  - Otherwise it selects the common cell a.
  - All ports use cur_bank as registered at the start of the cycle.
- Bank switch:
  - bank_req sampled on a rising edge loads cur_bank <= bank_id.
  - The new bank becomes visible the following cycle.
  - Writes and increments issued in the same cycle as bank_req target the old bank.
  - bank_id ≥ NUM_BANKS is ignored: cur_bank is held.
  - With NUM_BANKS = 1, bank_req is ignored.
- Reads:
  - Combinational.
  - BYPASS = 1: if a same-cycle commit (after priority resolution) targets the read address, the read port returns the value being written, including the incremented value. Pair reads bypass each half independently.
  - BYPASS = 0: reads return the pre-edge array contents.
- Writes: committed on the rising edge.
- Increment:
  - On the rising edge, target <= target + 1, modulo 2^DATA_W.
  - Next cycle: inc_valid = 1; inc_zero = 1 iff the new value is 0.
  - With no inc_en: inc_valid = 0 and inc_zero holds its last value.
- Collision priority, resolved per target cell, highest first: pair write > single write > increment.
  - A lower-priority operation that loses to a higher one is dropped.
  - A dropped increment still pulses inc_valid, and its inc_zero reflects the value actually written to the cell.
  - Non-colliding operations in the same cycle all commit.
- Latency summary: write → visible on the next-cycle read (same cycle with BYPASS = 1); bank switch → 1 cycle; inc flags → 1 cycle.

Test Plan:
- Reset, then read all 16 addresses and all 8 pairs → all 0; cur_bank = 0.
- Bank 0: write R3 = 0xA. Switch to bank 1, then read R3 → 0x0. Write R12 = 0x5, switch back to bank 0, then read R3 → 0xA and R12 → 0x5 (R12 is common).
- Same cycle: bank_req = 1 (bank_id = 1), wr R2 = 0x7. Then read R2 → 0x0 in bank 1; switch to bank 0, read R2 → 0x7.
- R9 = 0xF, inc_en on R9 → next cycle R9 = 0x0, inc_valid = 1, inc_zero = 1. Increment R9 again → R9 = 0x1, inc_zero = 0.
- Same cycle: pw_en pair 1 = 0x3C, wr_en R2 = 0x9, inc_en R3 (R3 was 0x4) → R2 = 0x3, R3 = 0xC; inc_valid = 1, inc_zero = 0.
- BYPASS = 1: wr R5 = 0x6 with rda_addr = 5 → rda_data = 0x6 in the same cycle. BYPASS = 0 → old value. Assert rst_n low mid-sequence → all registers 0 and cur_bank = 0, immediately and asynchronously.
